sram_ctrl: RTL and testbench



---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_ctrl_if.sv | 44 ++++
 rtl/sram_arb.sv | 37 +++
 rtl/sram_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the external 256Kx16 asynchronous SRAM controller.
package sram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_t;

  // Active-high strobe bundle; the top level inverts these onto the pins.
  typedef struct packed {
    logic ce;
    logic oe;
    logic we;
    logic lb;
    logic hb;
  } sram_strobe_t;

  localparam sram_strobe_t STROBE_OFF = '0;

endpackage

// File: rtl/sram_ctrl_if.sv
// Requester ports (video read, fill/host write) and SRAM pin-side signals of sram_ctrl.
interface sram_ctrl_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ce;
  logic              ram_oe;
  logic              ram_we;
  logic              ram_lb;
  logic              ram_hb;

  // Controller side.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, ram_din,
    output rd_ack, rd_valid, rd_data, wr_ack,
           ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );

  // Requesters plus the SRAM device.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, ram_din,
    input  rd_ack, rd_valid, rd_data, wr_ack,
           ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );

endinterface

// File: rtl/sram_arb.sv
// Read-priority arbiter with write starvation guard; grants are only meaningful while the FSM is idle.
module sram_arb
  import sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk100,
  input  logic reset_n,
  input  logic i_idle,
  input  logic i_rd_req,
  input  logic i_wr_req,
  output logic o_grant_rd,
  output logic o_grant_wr
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved  = (r_starve_cnt == CNT_MAX);
  assign o_grant_wr = i_idle & i_wr_req & (w_starved | ~i_rd_req);
  assign o_grant_rd = i_idle & i_rd_req & ~o_grant_wr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (o_grant_wr) begin
      r_starve_cnt <= '0;
    end else if (o_grant_rd && i_wr_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM sequencer: arbitrates read/write ports and drives registered CE/OE/WE/LB/HB strobes.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_WAIT    = 1,
  parameter int WRITE_WAIT   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk100,
  input  logic        reset_n,
  sram_ctrl_if.slave  bus
);

  localparam int WAIT_MAX = (READ_WAIT + 1 > WRITE_WAIT) ? READ_WAIT + 1 : WRITE_WAIT;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
  localparam sram_strobe_t RD_STROBE = '{ce: 1'b1, oe: 1'b1, we: 1'b0, lb: 1'b1, hb: 1'b1};

  sram_state_t       r_state;
  logic [CNT_W-1:0]  r_wait;
  sram_strobe_t      r_strobe;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_dout;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_ack;
  logic              r_rd_valid;
  logic              r_wr_ack;

  logic w_idle;
  logic w_grant_rd;
  logic w_grant_wr;

  assign w_idle = (r_state == ST_IDLE);

  sram_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk100     (clk100),
    .reset_n    (reset_n),
    .i_idle     (w_idle),
    .i_rd_req   (bus.rd_req),
    .i_wr_req   (bus.wr_req),
    .o_grant_rd (w_grant_rd),
    .o_grant_wr (w_grant_wr)
  );

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wait     <= '0;
      r_strobe   <= STROBE_OFF;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
      r_rd_data  <= '0;
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
    end else begin
      // Ack/valid are single-cycle pulses unless re-asserted below.
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_rd) begin
            r_state    <= ST_RD;
            r_rd_ack   <= 1'b1;
            r_ram_addr <= bus.rd_addr;
            r_strobe   <= RD_STROBE;
            r_wait     <= RD_LOAD;
          end else if (w_grant_wr) begin
            r_state    <= ST_WR_SETUP;
            r_wr_ack   <= 1'b1;
            r_ram_addr <= bus.wr_addr;
            r_ram_dout <= bus.wr_data;
            r_strobe   <= '{ce: 1'b1, oe: 1'b0, we: 1'b0, lb: bus.wr_be[0], hb: bus.wr_be[1]};
          end
        end

        ST_RD: begin
          if (r_wait == '0) begin
            r_rd_data  <= bus.ram_din;
            r_rd_valid <= 1'b1;
            r_strobe   <= STROBE_OFF;
            r_state    <= ST_IDLE;
          end else begin
            r_wait <= r_wait - CNT_W'(1);
          end
        end

        ST_WR_SETUP: begin
          r_strobe.we <= 1'b1;
          r_wait      <= WR_LOAD;
          r_state     <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (r_wait == '0) begin
            r_strobe.we <= 1'b0;
            r_state     <= ST_WR_HOLD;
          end else begin
            r_wait <= r_wait - CNT_W'(1);
          end
        end

        ST_WR_HOLD: begin
          r_strobe <= STROBE_OFF;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_strobe <= STROBE_OFF;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_ack   = r_rd_ack;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.wr_ack   = r_wr_ack;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_dout = r_ram_dout;
  assign bus.ram_ce   = r_strobe.ce;
  assign bus.ram_oe   = r_strobe.oe;
  assign bus.ram_we   = r_strobe.we;
  assign bus.ram_lb   = r_strobe.lb;
  assign bus.ram_hb   = r_strobe.hb;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default build (ifa/dut) plus a READ_WAIT=3/WRITE_WAIT=2 build (ifb/dut_b), each with an SRAM model.
module tb_sram_ctrl;

  logic clk100  = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc++;

  sram_ctrl_if #(.ADDR_W(18), .DATA_W(16)) ifa ();
  sram_ctrl_if #(.ADDR_W(18), .DATA_W(16)) ifb ();

  sram_ctrl #(
    .ADDR_W(18), .DATA_W(16), .READ_WAIT(1), .WRITE_WAIT(1), .STARVE_LIMIT(4)
  ) dut (
    .clk100 (clk100),
    .reset_n(reset_n),
    .bus    (ifa)
  );

  sram_ctrl #(
    .ADDR_W(18), .DATA_W(16), .READ_WAIT(3), .WRITE_WAIT(2), .STARVE_LIMIT(4)
  ) dut_b (
    .clk100 (clk100),
    .reset_n(reset_n),
    .bus    (ifb)
  );

  // SRAM device models: byte-lane writes while CE&WE, data driven while CE&OE.
  bit [15:0] mem_a    [0:262143];
  bit [15:0] mem_b    [0:262143];
  bit [15:0] shadow_a [0:262143];

  assign ifa.ram_din = (ifa.ram_ce && ifa.ram_oe) ? mem_a[ifa.ram_addr] : 16'hDEAD;
  assign ifb.ram_din = (ifb.ram_ce && ifb.ram_oe) ? mem_b[ifb.ram_addr] : 16'hDEAD;

  always @(posedge clk100) begin
    if (ifa.ram_ce && ifa.ram_we) begin
      if (ifa.ram_lb) mem_a[ifa.ram_addr][7:0]  <= ifa.ram_dout[7:0];
      if (ifa.ram_hb) mem_a[ifa.ram_addr][15:8] <= ifa.ram_dout[15:8];
    end
    if (ifb.ram_ce && ifb.ram_we) begin
      if (ifb.ram_lb) mem_b[ifb.ram_addr][7:0]  <= ifb.ram_dout[7:0];
      if (ifb.ram_hb) mem_b[ifb.ram_addr][15:8] <= ifb.ram_dout[15:8];
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
    merge = old_w;
    if (be[0]) merge[7:0]  = new_w[7:0];
    if (be[1]) merge[15:8] = new_w[15:8];
  endfunction

  // Scoreboard for the default build: expected words queued at issue, checked at rd_valid.
  logic [15:0] sb_q [$];

  always @(negedge clk100) begin
    logic [15:0] exp_w;
    if (reset_n && ifa.rd_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL rd_valid_unexpected: got data %h, required no rd_valid", ifa.rd_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (ifa.rd_data !== exp_w)
          $display("FAIL rd_data: got %h required %h", ifa.rd_data, exp_w);
        else
          n_pass++;
      end
    end
  end

  task automatic do_read(input logic [17:0] a, output int ack_rel, output int valid_rel,
                         output logic [4:0] stb1);
    int c0;
    ack_rel = -1; valid_rel = -1; stb1 = '0;
    @(negedge clk100);
    c0 = cyc;
    ifa.rd_addr = a;
    ifa.rd_req  = 1'b1;
    sb_q.push_back(shadow_a[a]);
    for (int i = 0; i < 20 && valid_rel < 0; i++) begin
      @(negedge clk100);
      if (ifa.rd_ack && ack_rel < 0) begin
        ack_rel = cyc - c0;
        ifa.rd_req = 1'b0;
      end
      if (cyc - c0 == 1) stb1 = {ifa.ram_ce, ifa.ram_oe, ifa.ram_we, ifa.ram_lb, ifa.ram_hb};
      if (ifa.rd_valid) valid_rel = cyc - c0;
    end
    ifa.rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                          output int ack_rel, output int we_cnt, output int ce_cnt,
                          output int we_first, output int oe_cnt);
    int c0;
    ack_rel = -1; we_cnt = 0; ce_cnt = 0; we_first = -1; oe_cnt = 0;
    @(negedge clk100);
    c0 = cyc;
    ifa.wr_addr = a; ifa.wr_data = d; ifa.wr_be = be;
    ifa.wr_req  = 1'b1;
    shadow_a[a] = merge(shadow_a[a], d, be);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk100);
      if (ifa.wr_ack && ack_rel < 0) begin
        ack_rel = cyc - c0;
        ifa.wr_req = 1'b0;
      end
      if (ifa.ram_we) begin
        we_cnt++;
        if (we_first < 0) we_first = cyc - c0;
      end
      if (ifa.ram_ce) ce_cnt++;
      if (ifa.ram_oe) oe_cnt++;
    end
    ifa.wr_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk100);
    reset_n = 1'b1;
    @(negedge clk100);
    n_checks++;
    if ({ifa.ram_ce, ifa.ram_oe, ifa.ram_we, ifa.ram_lb, ifa.ram_hb} !== 5'b0)
      $display("FAIL reset_strobes: got %b required 00000",
               {ifa.ram_ce, ifa.ram_oe, ifa.ram_we, ifa.ram_lb, ifa.ram_hb});
    else n_pass++;
    n_checks++;
    if (ifa.ram_addr !== 18'h0 || ifa.ram_dout !== 16'h0)
      $display("FAIL reset_addr_dout: got %h/%h required 0/0", ifa.ram_addr, ifa.ram_dout);
    else n_pass++;
    n_checks++;
    if (ifa.rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h required 0", ifa.rd_data);
    else n_pass++;
    n_checks++;
    if ({ifa.rd_ack, ifa.wr_ack, ifa.rd_valid} !== 3'b0)
      $display("FAIL reset_pulses: got %b required 000", {ifa.rd_ack, ifa.wr_ack, ifa.rd_valid});
    else n_pass++;
    n_checks++;
    if ({ifb.ram_ce, ifb.ram_oe, ifb.ram_we, ifb.ram_lb, ifb.ram_hb} !== 5'b0)
      $display("FAIL reset_strobes_b: got %b required 00000",
               {ifb.ram_ce, ifb.ram_oe, ifb.ram_we, ifb.ram_lb, ifb.ram_hb});
    else n_pass++;
  endtask

  task automatic test_read_basic();
    int ack_rel, valid_rel;
    logic [4:0] stb1;
    mem_a[18'h00010] = 16'hA5C3; shadow_a[18'h00010] = 16'hA5C3;
    do_read(18'h00010, ack_rel, valid_rel, stb1);
    n_checks++;
    if (ack_rel !== 1) $display("FAIL read_ack_cycle: got %0d required 1", ack_rel);
    else n_pass++;
    n_checks++;
    if (valid_rel !== 3) $display("FAIL read_valid_cycle: got %0d required 3", valid_rel);
    else n_pass++;
    n_checks++;
    if (stb1 !== 5'b11011) $display("FAIL read_strobes: got %b required 11011", stb1);
    else n_pass++;
    n_checks++;
    if (ifa.ram_addr !== 18'h00010) $display("FAIL read_addr: got %h required 00010", ifa.ram_addr);
    else n_pass++;
    n_checks++;
    if ({ifa.ram_ce, ifa.ram_oe} !== 2'b00)
      $display("FAIL read_idle_strobes: got %b required 00", {ifa.ram_ce, ifa.ram_oe});
    else n_pass++;
  endtask

  task automatic test_write_be();
    int ack_rel, we_cnt, ce_cnt, we_first, oe_cnt, vr;
    logic [4:0] stb1;
    mem_a[18'h3FFFF] = 16'hBEEF; shadow_a[18'h3FFFF] = 16'hBEEF;
    do_write(18'h3FFFF, 16'h1234, 2'b01, ack_rel, we_cnt, ce_cnt, we_first, oe_cnt);
    n_checks++;
    if (ack_rel !== 1) $display("FAIL write_ack_cycle: got %0d required 1", ack_rel);
    else n_pass++;
    n_checks++;
    if (we_cnt !== 1 || we_first !== 2)
      $display("FAIL write_we_pulse: got %0d cycles from %0d, required 1 from 2", we_cnt, we_first);
    else n_pass++;
    n_checks++;
    if (ce_cnt !== 3) $display("FAIL write_ce_cycles: got %0d required 3", ce_cnt);
    else n_pass++;
    n_checks++;
    if (oe_cnt !== 0) $display("FAIL write_oe: got %0d cycles required 0", oe_cnt);
    else n_pass++;
    do_read(18'h3FFFF, ack_rel, vr, stb1);
    n_checks++;
    if (vr !== 3) $display("FAIL readback_valid_cycle: got %0d required 3", vr);
    else n_pass++;
    // High lane only, then no lanes: word must become 5A11 and stay there.
    mem_a[18'h00020] = 16'h1111; shadow_a[18'h00020] = 16'h1111;
    do_write(18'h00020, 16'h5A5A, 2'b10, ack_rel, we_cnt, ce_cnt, we_first, oe_cnt);
    do_write(18'h00020, 16'hFFFF, 2'b00, ack_rel, we_cnt, ce_cnt, we_first, oe_cnt);
    n_checks++;
    if (we_cnt !== 1 || ce_cnt !== 3)
      $display("FAIL write_be00_sequence: got we %0d ce %0d required we 1 ce 3", we_cnt, ce_cnt);
    else n_pass++;
    do_read(18'h00020, ack_rel, vr, stb1);
  endtask

  task automatic test_starve();
    logic [9:0] got;
    int n;
    got = '0; n = 0;
    mem_a[18'h00100] = 16'h0F0F; shadow_a[18'h00100] = 16'h0F0F;
    @(negedge clk100);
    ifa.rd_addr = 18'h00100; ifa.rd_req = 1'b1;
    ifa.wr_addr = 18'h00200; ifa.wr_data = 16'h7777; ifa.wr_be = 2'b11; ifa.wr_req = 1'b1;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk100);
      if (ifa.rd_ack) begin
        got[9-n] = 1'b0; n++;
        sb_q.push_back(shadow_a[18'h00100]);
      end
      if (ifa.wr_ack) begin
        got[9-n] = 1'b1; n++;
        shadow_a[18'h00200] = ifa.wr_data;
        ifa.wr_data = 16'h8888;
      end
    end
    ifa.rd_req = 1'b0; ifa.wr_req = 1'b0;
    n_checks++;
    if (n !== 10) $display("FAIL starve_grant_count: got %0d grants required 10", n);
    else n_pass++;
    n_checks++;
    if (got !== 10'b0000100001) $display("FAIL starve_order: got %b required 0000100001", got);
    else n_pass++;
    repeat (6) @(negedge clk100);
  endtask

  task automatic test_simultaneous();
    int c0, ra, rv, wa;
    ra = -1; rv = -1; wa = -1;
    mem_a[18'h00300] = 16'hC0DE; shadow_a[18'h00300] = 16'hC0DE;
    @(negedge clk100);
    c0 = cyc;
    ifa.rd_addr = 18'h00300; ifa.rd_req = 1'b1;
    ifa.wr_addr = 18'h00301; ifa.wr_data = 16'h4242; ifa.wr_be = 2'b11; ifa.wr_req = 1'b1;
    sb_q.push_back(shadow_a[18'h00300]);
    shadow_a[18'h00301] = 16'h4242;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk100);
      if (ifa.rd_ack && ra < 0) begin ra = cyc - c0; ifa.rd_req = 1'b0; end
      if (ifa.rd_valid && rv < 0) rv = cyc - c0;
      if (ifa.wr_ack && wa < 0) begin wa = cyc - c0; ifa.wr_req = 1'b0; end
    end
    n_checks++;
    if (ra !== 1 || rv !== 3)
      $display("FAIL simul_read_first: got ack %0d valid %0d required 1 and 3", ra, rv);
    else n_pass++;
    n_checks++;
    if (wa !== 4) $display("FAIL simul_write_after: got wr_ack %0d required 4", wa);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0, stray, ack_rel, vr;
    logic [4:0] stb1;
    stray = 0;
    mem_a[18'h00400] = 16'h1357; shadow_a[18'h00400] = 16'h1357;
    @(negedge clk100);
    c0 = cyc;
    ifa.wr_addr = 18'h00400; ifa.wr_data = 16'h9999; ifa.wr_be = 2'b11; ifa.wr_req = 1'b1;
    while (cyc - c0 < 2) @(negedge clk100);
    ifa.wr_req = 1'b0;
    n_checks++;
    if (ifa.ram_we !== 1'b1) $display("FAIL midreset_pulse_active: got we %b required 1", ifa.ram_we);
    else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ifa.ram_we, ifa.ram_ce} !== 2'b00)
      $display("FAIL midreset_async_drop: got we/ce %b required 00", {ifa.ram_we, ifa.ram_ce});
    else n_pass++;
    @(negedge clk100);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk100);
      if (ifa.wr_ack || ifa.rd_valid || ifa.ram_ce) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL midreset_no_followup: got %0d active cycles required 0", stray);
    else n_pass++;
    do_read(18'h00400, ack_rel, vr, stb1);
    n_checks++;
    if (ack_rel !== 1 || vr !== 3)
      $display("FAIL midreset_next_read: got ack %0d valid %0d required 1 and 3", ack_rel, vr);
    else n_pass++;
  endtask

  task automatic test_params();
    int c0, ack1, ack2, vr, we_cnt, ce_cnt, we_first;
    logic [15:0] data_v;
    ack1 = -1; ack2 = -1; vr = -1; we_cnt = 0; ce_cnt = 0; we_first = -1; data_v = '0;
    mem_b[18'h00055] = 16'h6C6C;
    @(negedge clk100);
    c0 = cyc;
    ifb.rd_addr = 18'h00055; ifb.rd_req = 1'b1;
    for (int i = 0; i < 20 && ack2 < 0; i++) begin
      @(negedge clk100);
      if (ifb.rd_ack) begin
        if (ack1 < 0) ack1 = cyc - c0;
        else begin ack2 = cyc - c0; ifb.rd_req = 1'b0; end
      end
      if (ifb.rd_valid && vr < 0) begin vr = cyc - c0; data_v = ifb.rd_data; end
    end
    ifb.rd_req = 1'b0;
    n_checks++;
    if (ack1 !== 1 || vr !== 5)
      $display("FAIL wide_read_timing: got ack %0d valid %0d required 1 and 5", ack1, vr);
    else n_pass++;
    n_checks++;
    if (data_v !== 16'h6C6C) $display("FAIL wide_read_data: got %h required 6C6C", data_v);
    else n_pass++;
    n_checks++;
    if (ack2 - ack1 !== 5) $display("FAIL wide_b2b_spacing: got %0d required 5", ack2 - ack1);
    else n_pass++;
    repeat (8) @(negedge clk100);
    c0 = cyc;
    ifb.wr_addr = 18'h00056; ifb.wr_data = 16'hABCD; ifb.wr_be = 2'b11; ifb.wr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100);
      if (ifb.wr_ack) ifb.wr_req = 1'b0;
      if (ifb.ram_we) begin we_cnt++; if (we_first < 0) we_first = cyc - c0; end
      if (ifb.ram_ce) ce_cnt++;
    end
    ifb.wr_req = 1'b0;
    n_checks++;
    if (we_cnt !== 2 || we_first !== 2 || ce_cnt !== 4)
      $display("FAIL wide_write: got we %0d from %0d ce %0d required we 2 from 2 ce 4",
               we_cnt, we_first, ce_cnt);
    else n_pass++;
    n_checks++;
    if (mem_b[18'h00056] !== 16'hABCD)
      $display("FAIL wide_write_mem: got %h required ABCD", mem_b[18'h00056]);
    else n_pass++;
  endtask

  initial begin
    ifa.rd_req = 1'b0; ifa.rd_addr = '0; ifa.wr_req = 1'b0;
    ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_be = '0;
    ifb.rd_req = 1'b0; ifb.rd_addr = '0; ifb.wr_req = 1'b0;
    ifb.wr_addr = '0; ifb.wr_data = '0; ifb.wr_be = '0;

    test_reset();
    test_read_basic();
    test_write_be();
    test_starve();
    test_simultaneous();
    test_reset_mid();
    test_params();

    repeat (4) @(negedge clk100);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending reads required 0", sb_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
